// File: rtl/btn_dir_ctrl.sv
// Direction-button front end: tick prescaler, 3-sample debounce, press edge detect,
// round-robin arbitration, reversal/no-op filter and a small command FIFO.
// Optional BTN_DIR_DROP_CNT_EN adds a saturating discarded-press counter (drop_cnt).
module btn_dir_ctrl #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [1:0] cur_dir,
  output logic       tick,
  output logic [3:0] btn_level,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
`ifdef BTN_DIR_DROP_CNT_EN
  output logic [7:0] drop_cnt,
`endif
  input  logic       cmd_ready
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [CW-1:0] cnt;
  logic [2:0]    sh [4];
  logic [3:0]    lvl_q;
  logic [1:0]    rr_ptr;
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;

  logic [3:0]    press;
  logic          found, multi, reject, accept, push, pop, empty, full, discard;
  logic [1:0]    grant_dir, ref_dir, head_n;
  logic [AW:0]   wptr_n, rptr_n;
  logic [AW-1:0] widx, ridx, tail_idx;

  assign press    = btn_level & ~lvl_q;
  assign widx     = wptr[AW-1:0];
  assign ridx     = rptr[AW-1:0];
  assign tail_idx = widx - AW'(1);
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (widx == ridx);
  assign pop      = cmd_valid & cmd_ready;

  // Round-robin grant, filter against the newest queued heading, FIFO pointer update.
  always_comb begin
    found     = 1'b0;
    grant_dir = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && press[rr_ptr + 2'(k)]) begin
        found     = 1'b1;
        grant_dir = rr_ptr + 2'(k);
      end
    end
    multi   = (press & (press - 4'd1)) != 4'd0;
    ref_dir = empty ? cur_dir : mem[tail_idx];
    reject  = (grant_dir == ref_dir) || (grant_dir == (ref_dir ^ 2'b01));
    accept  = found & ~reject;
    push    = accept & (~full | pop);
    discard = multi | (found & reject) | (accept & ~push);
    wptr_n  = wptr + (AW+1)'(push);
    rptr_n  = rptr + (AW+1)'(pop);
    head_n  = (push && (widx == rptr_n[AW-1:0])) ? grant_dir : mem[rptr_n[AW-1:0]];
  end

  // Prescaler and tick strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(TICK_DIV - 1));
      cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
    end
  end

  // Debounce in the tick domain plus one-cycle level delay for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sh[i] <= 3'b000;
      btn_level <= 4'd0;
      lvl_q     <= 4'd0;
    end else begin
      lvl_q <= btn_level;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          sh[i]        <= {sh[i][1:0], btn_raw[i]};
          btn_level[i] <= (sh[i] == 3'b111);
        end
      end
    end
  end

  // Arbitration pointer and command FIFO; head is registered from next-state pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 2'd0;
      wptr      <= '0;
      rptr      <= '0;
      cmd_valid <= 1'b0;
      cmd_dir   <= 2'd0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 2'd0;
    end else begin
      if (found) rr_ptr <= grant_dir + 2'd1;
      if (push) mem[widx] <= grant_dir;
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      cmd_valid <= (wptr_n != rptr_n);
      cmd_dir   <= head_n;
    end
  end

`ifdef BTN_DIR_DROP_CNT_EN
  // One count per cycle with any discarded press, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= 8'd0;
    else if (discard && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Randomized bench for btn_dir_ctrl against a queue/run-length reference model.
module tb_btn_dir_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'd0;
  logic [1:0] cur_dir = 2'd0;
  logic       cmd_ready = 1'b0;
  logic       tick, cmd_valid;
  logic [3:0] btn_level;
  logic [1:0] cmd_dir;
`ifdef BTN_DIR_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  btn_dir_ctrl #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .cur_dir(cur_dir),
    .tick(tick), .btn_level(btn_level), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
`ifdef BTN_DIR_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int       m_cnt;
  bit       m_tick;
  int       m_run [4];
  bit [3:0] m_lvl, m_lvl_prev;
  int       m_rr;
  int       q[$];
  int       m_drop;

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_lvl = 0; m_lvl_prev = 0; m_rr = 0; m_drop = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit [3:0] press;
    bit [3:0] nl;
    int g, nset, rf;
    bit pop, push, discard;
    press = m_lvl & ~m_lvl_prev;
    g = -1; nset = 0; push = 0; discard = 0;
    pop = (q.size() > 0) && cmd_ready;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (press[i]) nset++;
      if (g < 0 && press[i]) g = i;
    end
    if (nset > 1) discard = 1;
    if (g >= 0) begin
      m_rr = (g + 1) % 4;
      rf = (q.size() > 0) ? q[$] : int'(cur_dir);
      if (g == rf || g == (rf ^ 1)) discard = 1;
      else if (q.size() < DEPTH || pop) push = 1;
      else discard = 1;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(g);
    if (discard && m_drop < 255) m_drop++;
    m_lvl_prev = m_lvl;
    if (m_tick) begin
      for (int i = 0; i < 4; i++) begin
        nl[i] = (m_run[i] >= 3);
        m_run[i] = btn_raw[i] ? ((m_run[i] >= 3) ? 3 : m_run[i] + 1) : 0;
      end
      m_lvl = nl;
    end
    m_tick = (m_cnt == TICK_DIV - 1);
    m_cnt = (m_cnt + 1) % TICK_DIV;
  endtask

  task automatic compare_all();
    check("tick", 32'(tick), 32'(m_tick));
    check("btn_level", 32'(btn_level), 32'(m_lvl));
    check("cmd_valid", 32'(cmd_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("cmd_dir", 32'(cmd_dir), 32'(q[0]));
`ifdef BTN_DIR_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Called between edges; returns at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_dir", 32'(cmd_dir), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: inputs already driven; step model, compare, return at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 compare_all();
    @(negedge clk);
  endtask

  bit ready_mode;

  initial begin
    #2;
    do_reset();

    // Held up-button from reset: tick timing, level rise, one-cycle command, pop.
    btn_raw = 4'b0001; cur_dir = 2'd2; cmd_ready = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      cycle();
      if (n == 3)  check("pre_tick", 32'(tick), 32'd0);
      if (n == 4)  check("first_tick", 32'(tick), 32'd1);
      if (n == 16) check("lvl_before", 32'(btn_level), 32'd0);
      if (n == 17) check("lvl_rise", 32'(btn_level), 32'd1);
      if (n == 17) check("no_cmd_yet", 32'(cmd_valid), 32'd0);
      if (n == 18) check("cmd_valid_up", 32'(cmd_valid), 32'd1);
      if (n == 18) check("cmd_dir_up", 32'(cmd_dir), 32'd0);
      if (n == 19) check("popped", 32'(cmd_valid), 32'd0);
    end

    // Randomized held/bouncing buttons, headings, back-pressure and resets.
    ready_mode = 1'b1;
    for (int n = 0; n < 9000; n++) begin
      if ($urandom_range(0, 23) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) btn_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) cur_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) ready_mode = ~ready_mode;
      cmd_ready = ready_mode & 1'($urandom_range(0, 1));
      cycle();
      if ($urandom_range(0, 2499) == 0) begin
        #1 do_reset();
      end
    end

    // Mid-operation reset with a queued command and a high debounced level.
    btn_raw = 4'b0001; cur_dir = 2'd2; cmd_ready = 1'b0;
    #1 do_reset();
    for (int n = 1; n <= 18; n++) cycle();
    check("pre_rst_valid", 32'(cmd_valid), 32'd1);
    check("pre_rst_level", 32'(btn_level), 32'd1);
    #1 do_reset();
    btn_raw = 4'b0000;
    for (int n = 1; n <= 30; n++) cycle();
    check("post_rst_idle", 32'(cmd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
